// File: rtl/audio_pwm_dac_if.sv
// CPU data-bus port of the audio PWM DAC: byte address, write data and strobe in, combinational read data out.
interface audio_pwm_dac_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;

    modport master (output bus_addr, output bus_wdata, output bus_we, input bus_rdata);
    modport slave  (input bus_addr, input bus_wdata, input bus_we, output bus_rdata);
endinterface

// File: rtl/audio_pwm_dac.sv
// Memory-mapped PCM sample FIFO + sample-rate timer + PWM generator; AUDIO_PWM_IRQ_EN enables the low-watermark irq.
// Latency: register writes land next cycle, reads are combinational, pwm_out lags the PWM counter by one cycle.
// Backpressure: none on the bus; pushes into a full FIFO are dropped (overflow), pops from empty hold the duty (underrun).
module audio_pwm_dac #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PWM_BITS   = 8,
    parameter int          DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    audio_pwm_dac_if.slave   bus,
    output logic             pwm_out,
    output logic             fifo_irq
);

    localparam int                AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [3:0]  rsvd_lo;
        logic        overflow;
        logic        underrun;
        logic        full;
        logic        empty;
    } status_t;

    logic                hit;
    logic [1:0]          reg_sel;
    logic                wr_data, wr_ctrl, wr_div, wr_stat;

    logic [PWM_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                empty, full;
    logic                do_push, do_pop;

    logic                en;
    logic [DIV_W-1:0]    div_reg, div_cnt;
    logic                tick;
    logic                underrun, overflow;
    logic [PWM_BITS-1:0] pwm_cnt, duty, duty_pend;
    status_t             status;
    logic                unused_bits;

    assign hit     = bus.bus_addr[31:4] == BASE_ADDR[31:4];
    assign reg_sel = bus.bus_addr[3:2];
    assign wr_data = bus.bus_we && hit && (reg_sel == 2'd0);
    assign wr_ctrl = bus.bus_we && hit && (reg_sel == 2'd1);
    assign wr_div  = bus.bus_we && hit && (reg_sel == 2'd2);
    assign wr_stat = bus.bus_we && hit && (reg_sel == 2'd3);

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:PWM_BITS]};

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // ">=" rather than "==" so a DIV written below the running count wraps on the next cycle.
    assign tick    = en && (div_cnt >= div_reg);
    assign do_pop  = tick && !empty;
    assign do_push = wr_data && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.bus_wdata[PWM_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            en        <= 1'b0;
            div_reg   <= '1;
            div_cnt   <= '0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            pwm_cnt   <= '0;
            duty      <= '0;
            duty_pend <= '0;
            pwm_out   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (do_pop)  duty_pend <= mem[rd_ptr];
            if (wr_ctrl) en        <= bus.bus_wdata[0];
            if (wr_div)  div_reg   <= bus.bus_wdata[DIV_W-1:0];

            // Sticky flags: a same-cycle set beats the write-1-clear.
            underrun <= (underrun && !(wr_stat && bus.bus_wdata[2])) || (tick && empty);
            overflow <= (overflow && !(wr_stat && bus.bus_wdata[3])) || (wr_data && full && !do_pop);

            if (!en) begin
                div_cnt <= '0;
                pwm_cnt <= '0;
                pwm_out <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (pwm_cnt == PWM_MAX) duty <= duty_pend;
                pwm_out <= (pwm_cnt < duty);
            end
        end
    end

`ifdef AUDIO_PWM_IRQ_EN
    localparam logic [AW:0] HALF_CNT = (AW+1)'(FIFO_DEPTH / 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_irq <= 1'b0;
        end else begin
            fifo_irq <= en && (count <= HALF_CNT);
        end
    end
`else
    assign fifo_irq = 1'b0;
`endif

    always_comb begin
        status          = '0;
        status.count    = 8'(count);
        status.overflow = overflow;
        status.underrun = underrun;
        status.full     = full;
        status.empty    = empty;

        bus.bus_rdata = '0;
        if (hit) begin
            case (reg_sel)
                2'd1:    bus.bus_rdata = {31'b0, en};
                2'd2:    bus.bus_rdata = 32'(div_reg);
                2'd3:    bus.bus_rdata = status;
                default: bus.bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: register map, FIFO corner cases, sample timer and PWM duty counts.
module tb_audio_pwm_dac;

    localparam logic [31:0] A_DATA = 32'h8000_0000;
    localparam logic [31:0] A_CTRL = 32'h8000_0004;
    localparam logic [31:0] A_DIV  = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;
`ifdef AUDIO_PWM_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_out;
    logic fifo_irq;
    int   checks = 0;
    int   errors = 0;

    audio_pwm_dac_if bus_if ();

    audio_pwm_dac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .pwm_out  (pwm_out),
        .fifo_irq (fifo_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_we    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.bus_addr = a;
        #1;
        d = bus_if.bus_rdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (pwm_out) hi++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int hi;
        int h1, h2, h3, first;

        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_we    = 1'b0;

        // Reset values and address decode
        do_reset();
        bus_read(A_STAT, rd);  check_eq("rst_status", rd, 32'h0000_0001);
        bus_read(A_CTRL, rd);  check_eq("rst_ctrl", rd, 32'h0);
        bus_read(A_DIV, rd);   check_eq("rst_div", rd, 32'h0000_FFFF);
        check_eq("rst_pwm", {31'b0, pwm_out}, 32'h0);
        check_eq("rst_irq", {31'b0, fifo_irq}, 32'h0);
        bus_write(32'h9000_0004, 32'h1);
        bus_read(A_CTRL, rd);  check_eq("miss_write_ignored", rd, 32'h0);
        bus_read(32'h9000_000C, rd); check_eq("miss_read_zero", rd, 32'h0);

        // Overflow with EN=0: 17 pushes, last dropped
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h10 + 32'(i));
        bus_write(A_DATA, 32'hEE);
        bus_read(A_STAT, rd);  check_eq("ovf_status", rd, 32'h0000_100A);
        bus_write(A_STAT, 32'h8);
        bus_read(A_STAT, rd);  check_eq("ovf_clear", rd, 32'h0000_1002);

        // Full FIFO: push coincides with the first tick (4th edge after EN)
        bus_write(A_DIV, 32'd3);
        bus_write(A_CTRL, 32'h1);
        step(3);
        bus_write(A_DATA, 32'h99);
        bus_read(A_STAT, rd);  check_eq("full_pushpop_status", rd, 32'h0000_1002);

        // Order check: one pop per frame, duty = sample popped one frame earlier
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DIV, 32'd255);
        bus_write(A_CTRL, 32'h1);
        count_high(256, hi);   check_eq("order_w1_duty0", 32'(hi), 32'd0);
        count_high(256, hi);   check_eq("order_w2_0x10", 32'(hi), 32'd16);
        count_high(256, hi);   check_eq("order_w3_0x11", 32'(hi), 32'd17);
        count_high(256, hi);   check_eq("order_w4_0x12", 32'(hi), 32'd18);
        bus_read(A_STAT, rd);  check_eq("order_count12", rd, 32'h0000_0C00);

        // Drain with DIV=0: tail entry 0x99 ends up as duty, underrun holds it
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DIV, 32'd0);
        bus_write(A_CTRL, 32'h1);
        count_high(256, hi);   check_eq("duty_held_0x13", 32'(hi), 32'd19);
        count_high(256, hi);   check_eq("tail_0x99", 32'(hi), 32'd153);
        bus_read(A_STAT, rd);  check_eq("drain_status", rd, 32'h0000_0005);
        bus_write(A_STAT, 32'h4);
        bus_read(A_STAT, rd);  check_eq("w1c_loses_to_set", rd, 32'h0000_0005);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h4);
        bus_read(A_STAT, rd);  check_eq("w1c_underrun", rd, 32'h0000_0001);

        // Underrun on an empty FIFO at the 4th edge after EN
        do_reset();
        bus_write(A_DIV, 32'd3);
        bus_write(A_CTRL, 32'h1);
        step(3);
        bus_read(A_STAT, rd);  check_eq("udr_before_tick", rd, 32'h0000_0001);
        step(1);
        bus_read(A_STAT, rd);  check_eq("udr_at_tick", rd, 32'h0000_0005);
        count_high(300, hi);   check_eq("udr_pwm_low", 32'(hi), 32'd0);

        // PWM duty 0x40: first full frame after the tick is 64/256 high
        do_reset();
        bus_write(A_DIV, 32'd3);
        bus_write(A_DATA, 32'h40);
        bus_write(A_CTRL, 32'h1);
        h1 = 0; h2 = 0; h3 = 0; first = 0;
        for (int n = 1; n <= 768; n++) begin
            step(1);
            if (pwm_out) begin
                if (first == 0) first = n;
                if (n <= 256)      h1++;
                else if (n <= 512) h2++;
                else               h3++;
            end
        end
        check_eq("pwm_frame1", 32'(h1), 32'd0);
        check_eq("pwm_frame2", 32'(h2), 32'd64);
        check_eq("pwm_frame3", 32'(h3), 32'd64);
        check_eq("pwm_first_high", 32'(first), 32'd257);

        // Mid-frame reset with samples queued
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h80);
        bus_write(A_DIV, 32'd100);
        bus_write(A_CTRL, 32'h1);
        step(260);
        check_eq("mid_pwm_high", {31'b0, pwm_out}, 32'h1);
        check_eq("mid_irq", {31'b0, fifo_irq}, IRQ_ON);
        bus_read(A_STAT, rd);  check_eq("mid_status", rd, 32'h0000_0100);
        rst_n = 1'b0;
        step(1);
        check_eq("mrst_pwm", {31'b0, pwm_out}, 32'h0);
        check_eq("mrst_irq", {31'b0, fifo_irq}, 32'h0);
        bus_read(A_STAT, rd);  check_eq("mrst_status", rd, 32'h0000_0001);
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
